// File: rtl/rr_mux_arbiter_4to1_pkg.sv
// Shared types and constants for the 4-requester round-robin mux arbiter.
package arb_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int N_REQ         = 4;
  localparam int SEL_W         = 2;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;
endpackage

// File: rtl/rr_mux_arbiter_4to1_if.sv
// Requester/downstream bundle of rr_mux_arbiter_4to1; slave = arbiter side, master = driver side.
interface rr_mux_arbiter_4to1_if #(
  parameter int DATA_W = 8
);
  import arb_pkg::*;

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data_in;
  logic                    out_ready;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic [N_REQ-1:0]        grant;
  logic [SEL_W-1:0]        sel;
  logic                    busy;

  // A beat moves on a rising edge where out_valid && out_ready; out_valid never waits on
  // out_ready, and out_data is only meaningful while out_valid is high.
  modport master (
    output req, data_in, out_ready,
    input  out_valid, out_data, grant, sel, busy
  );

  modport slave (
    input  req, data_in, out_ready,
    output out_valid, out_data, grant, sel, busy
  );
endinterface

// File: rtl/rr_pick4.sv
// Combinational winner pick for 4 requesters: round-robin after last_ptr by default,
// fixed priority (0 highest) when ARB_FIXED_PRIO_EN is defined.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_ptr,
  output logic             valid,
  output logic [SEL_W-1:0] winner
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_last_ptr;
  assign unused_last_ptr = ^last_ptr;

  always_comb begin
    valid  = |req;
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) winner = SEL_W'(i);
    end
  end
`else
  logic [SEL_W-1:0] idx;

  // Walk from the farthest candidate back to last_ptr+1 so the nearest hit is assigned last.
  always_comb begin
    valid  = |req;
    winner = '0;
    idx    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = last_ptr + SEL_W'(i);
      if (req[idx]) winner = idx;
    end
  end
`endif

endmodule

// File: rtl/rr_mux_arbiter_4to1.sv
// Arbiter owning a 4:1 data mux with burst-capped grants (busy mirrors the FSM state).
// Build option: ARB_FIXED_PRIO_EN selects fixed-priority picking instead of round-robin.
module rr_mux_arbiter_4to1
  import arb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_mux_arbiter_4to1_if.slave bus
);

  localparam int                CNT_W     = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pick_valid;
  logic [SEL_W-1:0] pick_winner;
  logic             owner_req;
  logic             xfer;

  rr_pick4 u_pick (
    .req      (bus.req),
    .last_ptr (last_q),
    .valid    (pick_valid),
    .winner   (pick_winner)
  );

  assign owner_req = bus.req[sel_q];
  assign xfer      = (state_q == BUSY) && owner_req && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          sel_d   = pick_winner;
          last_d  = pick_winner;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        // A withdrawn owner releases without a beat; the cap forces rotation otherwise.
        if (!owner_req) begin
          state_d = IDLE;
        end else if (xfer) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q == BUSY);
  assign bus.sel       = sel_q;
  assign bus.grant     = (state_q == BUSY) ? (N_REQ'(1) << sel_q) : '0;
  assign bus.out_valid = (state_q == BUSY) && owner_req;
  assign bus.out_data  = bus.data_in[sel_q*DATA_W +: DATA_W];

endmodule
